// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared opcodes, ALU select codes and FSM state encoding for the
// accumulator-style ALU command sequencer.
package alu_seq_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_NOT   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_DBL   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_EMIT  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  // Select codes understood by the attached combinational ALU
  localparam logic [1:0] SEL_NOT = 2'b00;
  localparam logic [1:0] SEL_ADD = 2'b01;
  localparam logic [1:0] SEL_SUB = 2'b10;
  localparam logic [1:0] SEL_DBL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MULT = 2'b10,
    ST_EMIT = 2'b11
  } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command channel, result channel and ALU port signals
// seen by the sequencer.
//
// Handshake rule for both channels: a transfer happens on a rising clk
// edge where valid && ready are both high. A producer holds valid and its
// payload stable until that edge; ready never depends combinationally on
// valid.
interface alu_cmd_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_y;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;

  logic             busy;
  state_t           state_dbg;

  // Environment side: issues commands, answers ALU, consumes results
  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_y, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_zero,
           busy, state_dbg
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_y, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_zero,
           busy, state_dbg
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Accumulator-style command sequencer driving an external combinational
// ALU. Holds the accumulator, steps multi-cycle multiply as repeated ADD,
// and hands accumulator snapshots out on the result channel.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  alu_cmd_sequencer_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] mul_base;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] res_data_q;
  logic             res_zero_q;
  logic [WIDTH-1:0] alu_b_c;
  logic [1:0]       alu_sel_c;

  // Main FSM: command accept, ALU write-back, multiply stepping, result hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      opnd       <= '0;
      sel_q      <= SEL_NOT;
      mul_base   <= '0;
      cnt        <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd_op)
              OP_LOAD:  acc <= bus.cmd_data;
              OP_CLEAR: acc <= '0;
              OP_NOT: begin
                opnd  <= bus.cmd_data;
                sel_q <= SEL_NOT;
                state <= ST_EXEC;
              end
              OP_ADD: begin
                opnd  <= bus.cmd_data;
                sel_q <= SEL_ADD;
                state <= ST_EXEC;
              end
              OP_SUB: begin
                opnd  <= bus.cmd_data;
                sel_q <= SEL_SUB;
                state <= ST_EXEC;
              end
              OP_DBL: begin
                opnd  <= bus.cmd_data;
                sel_q <= SEL_DBL;
                state <= ST_EXEC;
              end
              OP_MUL: begin
                // Product is built by adding the old acc 'data' times onto 0
                mul_base <= acc;
                cnt      <= bus.cmd_data;
                acc      <= '0;
                state    <= ST_MULT;
              end
              OP_EMIT: begin
                res_data_q <= acc;
                res_zero_q <= (acc == '0);
                state      <= ST_EMIT;
              end
              default: ;
            endcase
          end
        end
        ST_EXEC: begin
          acc   <= bus.alu_y;
          state <= ST_IDLE;
        end
        ST_MULT: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            acc <= bus.alu_y;
            cnt <= cnt - 1'b1;
          end
        end
        ST_EMIT: begin
          if (bus.res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ALU operand B / select: decoded from state and latched operands only
  always_comb begin
    alu_b_c   = '0;
    alu_sel_c = SEL_NOT;
    case (state)
      ST_EXEC: begin
        alu_b_c   = opnd;
        alu_sel_c = sel_q;
      end
      ST_MULT: begin
        alu_b_c   = mul_base;
        alu_sel_c = SEL_ADD;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.res_valid = (state == ST_EMIT);
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.alu_a     = acc;
  assign bus.alu_b     = alu_b_c;
  assign bus.alu_sel   = alu_sel_c;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural 4-bit ALU as responder.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   model_acc;

  logic [WIDTH:0] exp_q[$];

  alu_cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_cmd_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: the team's combinational ALU
  always_comb begin
    case (bus.alu_sel)
      2'b00:   bus.alu_y = ~bus.alu_a;
      2'b01:   bus.alu_y = bus.alu_a + bus.alu_b;
      2'b10:   bus.alu_y = bus.alu_a - bus.alu_b;
      default: bus.alu_y = bus.alu_a + bus.alu_a;
    endcase
  end

  // ---------------- reference model ----------------
  task automatic model_apply(input logic [2:0] op, input int data);
    case (op)
      OP_LOAD:  model_acc = data;
      OP_NOT:   model_acc = 15 - model_acc;
      OP_ADD:   model_acc = (model_acc + data) % 16;
      OP_SUB:   model_acc = (model_acc - data + 16) % 16;
      OP_DBL:   model_acc = (model_acc * 2) % 16;
      OP_MUL:   model_acc = (model_acc * data) % 16;
      OP_EMIT:  exp_q.push_back({(model_acc == 0), 4'(model_acc)});
      default:  model_acc = 0;
    endcase
  endtask

  // ---------------- driver ----------------
  // Returns at #1 after the accept edge.
  task automatic send_cmd(input logic [2:0] op, input int data);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL cmd_wait: cmd_ready=%0b after %0d cycles, required 1", bus.cmd_ready, n);
    end else begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = 4'(data);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      model_apply(op, data);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL result_unexpected: got data=%h zero=%0b, none expected",
                 bus.res_data, bus.res_zero);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        if ({bus.res_zero, bus.res_data} !== e) begin
          tests_failed++;
          $display("FAIL result: got data=%h zero=%0b, required data=%h zero=%0b",
                   bus.res_data, bus.res_zero, e[WIDTH-1:0], e[WIDTH]);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.cmd_ready, bus.busy, bus.res_valid, bus.res_zero} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL reset_ctrl: rdy/busy/vld/zero=%b, required 1001",
               {bus.cmd_ready, bus.busy, bus.res_valid, bus.res_zero});
    end
    tests_run++;
    if ({bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_data} !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_data: a=%h b=%h sel=%b res=%h, required all 0",
               bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_data);
    end
    tests_run++;
    if (bus.state_dbg !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: state=%0d, required IDLE", bus.state_dbg);
    end
    @(negedge clk);
    rst = 1'b0;
    model_acc = 0;
  endtask

  task automatic test_add();
    send_cmd(OP_LOAD, 5);
    send_cmd(OP_ADD, 3);
    tests_run++;
    if ({bus.cmd_ready, bus.alu_sel, bus.alu_a, bus.alu_b} !== {1'b0, 2'b01, 4'd5, 4'd3}) begin
      tests_failed++;
      $display("FAIL add_exec: rdy=%0b sel=%b a=%h b=%h, required rdy=0 sel=01 a=5 b=3",
               bus.cmd_ready, bus.alu_sel, bus.alu_a, bus.alu_b);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({bus.cmd_ready, bus.alu_a} !== {1'b1, 4'd8}) begin
      tests_failed++;
      $display("FAIL add_done: rdy=%0b acc=%h, required rdy=1 acc=8", bus.cmd_ready, bus.alu_a);
    end
    send_cmd(OP_EMIT, 0);
    wait_drain();
  endtask

  task automatic test_sub_clear();
    send_cmd(OP_LOAD, 2);
    send_cmd(OP_SUB, 3);
    send_cmd(OP_EMIT, 0);
    send_cmd(OP_CLEAR, 0);
    send_cmd(OP_EMIT, 0);
    wait_drain();
  endtask

  task automatic test_dbl_not();
    send_cmd(OP_LOAD, 9);
    send_cmd(OP_DBL, 0);
    send_cmd(OP_EMIT, 0);
    send_cmd(OP_NOT, 0);
    send_cmd(OP_EMIT, 0);
    wait_drain();
  endtask

  task automatic test_mul();
    int n;
    send_cmd(OP_LOAD, 3);
    send_cmd(OP_MUL, 5);
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (n != 6) begin
      tests_failed++;
      $display("FAIL mul5_cycles: busy for %0d cycles, required 6", n);
    end
    send_cmd(OP_EMIT, 0);
    send_cmd(OP_LOAD, 7);
    send_cmd(OP_MUL, 0);
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (n != 1 || bus.alu_a !== 4'd0) begin
      tests_failed++;
      $display("FAIL mul0: busy %0d cycles acc=%h, required 1 cycle acc=0", n, bus.alu_a);
    end
    send_cmd(OP_LOAD, 6);
    send_cmd(OP_MUL, 6);
    send_cmd(OP_EMIT, 0);
    for (int i = 0; i < 3; i++) begin
      send_cmd(OP_LOAD, $urandom_range(0, 15));
      send_cmd(OP_MUL, $urandom_range(0, 15));
      send_cmd(OP_EMIT, 0);
    end
    wait_drain();
  endtask

  task automatic test_emit_stall();
    logic [WIDTH-1:0] v;
    send_cmd(OP_LOAD, 11);
    bus.res_ready = 1'b0;
    send_cmd(OP_EMIT, 0);
    v = 4'(model_acc);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({bus.res_valid, bus.cmd_ready, bus.res_data} !== {1'b1, 1'b0, v}) begin
        tests_failed++;
        $display("FAIL emit_hold[%0d]: vld=%0b rdy=%0b data=%h, required vld=1 rdy=0 data=%h",
                 i, bus.res_valid, bus.cmd_ready, bus.res_data, v);
      end
      @(posedge clk);
      #1;
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({bus.busy, bus.res_valid, bus.cmd_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL emit_release: busy/vld/rdy=%b, required 001",
               {bus.busy, bus.res_valid, bus.cmd_ready});
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    send_cmd(OP_LOAD, 3);
    send_cmd(OP_MUL, 6);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.alu_a, bus.alu_b, bus.busy, bus.cmd_ready, bus.res_valid} !== {4'd0, 4'd0, 3'b010}) begin
      tests_failed++;
      $display("FAIL rst_mul: acc=%h b=%h busy/rdy/vld=%b, required acc=0 b=0 010",
               bus.alu_a, bus.alu_b, {bus.busy, bus.cmd_ready, bus.res_valid});
    end
    #1;
    rst = 1'b0;
    model_acc = 0;
    bus.res_ready = 1'b0;
    send_cmd(OP_LOAD, 4);
    send_cmd(OP_EMIT, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.res_valid, bus.res_zero, bus.res_data, bus.busy, bus.cmd_ready, bus.alu_a} !==
        {1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 4'd0}) begin
      tests_failed++;
      $display("FAIL rst_emit: vld=%0b zero=%0b data=%h busy=%0b rdy=%0b acc=%h, required 0 1 0 0 1 0",
               bus.res_valid, bus.res_zero, bus.res_data, bus.busy, bus.cmd_ready, bus.alu_a);
    end
    exp_q.delete();
    #1;
    rst = 1'b0;
    model_acc = 0;
    bus.res_ready = 1'b1;
    send_cmd(OP_ADD, 7);
    send_cmd(OP_EMIT, 0);
    wait_drain();
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    model_acc     = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_add();
    test_sub_clear();
    test_dbl_not();
    test_mul();
    test_emit_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
